rcu_multi_vc: RTL and testbench

- Shared routing-computation unit for one router input port carrying NUM_VC virtual channels.
- Each cycle it arbitrates round-robin among VCs with a pending head flit and computes a Z-first, vertical-fault-tolerant output port for the winner.
- Result is presented through a one-stage registered valid/ready output to the VC allocator.
- Replaces the external random bit with an internal LFSR and adds a detour statistics counter.

---
 rtl/rcu_multi_vc_pkg.sv | 53 +++++
 rtl/rcu_multi_vc_if.sv | 33 +++
 rtl/rcu_multi_vc_route_calc.sv | 59 +++++
 rtl/rcu_multi_vc.sv | 115 +++++++++++
 tb/tb_rcu_multi_vc.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rcu_multi_vc_pkg.sv
// Shared types, constants and helpers for the multi-VC routing-computation unit.
package rcu_multi_vc_pkg;

   // Every mesh axis has the same extent, so one coordinate width serves all three.
   localparam int MESH_DIM = 4;
   localparam int COORD_W  = $clog2(MESH_DIM);
   localparam int HOP_W    = COORD_W + 1;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] z;
   } position_t;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      EAST  = 3'd1,
      WEST  = 3'd2,
      NORTH = 3'd3,
      SOUTH = 3'd4,
      UP    = 3'd5,
      DOWN  = 3'd6
   } port_t;

   typedef enum logic [1:0] {
      ZERO = 2'd0,
      POS  = 2'd1,
      NEG  = 2'd3
   } direction_t;

   // Feedback taps 16,14,13,11 of the Fibonacci LFSR, expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // A VC index needs at least one bit even when there is a single VC.
   function automatic int vc_idx_width(input int num_vc);
      return (num_vc > 1) ? $clog2(num_vc) : 1;
   endfunction

   localparam int NUM_VC_DEFAULT = 4;
   typedef logic [vc_idx_width(NUM_VC_DEFAULT)-1:0] vc_idx_t;

   // Sign of a hop count taken in two's complement with one extra bit.
   function automatic direction_t hop_dir(input logic [HOP_W-1:0] hops);
      if (hops == '0) begin
         return ZERO;
      end
      if (hops[HOP_W-1]) begin
         return NEG;
      end
      return POS;
   endfunction

endpackage

// File: rtl/rcu_multi_vc_if.sv
// Request/result bundle between the VC buffers, the routing unit and the VC allocator.
interface rcu_multi_vc_if #(
   parameter int NUM_VC = 4,
   parameter int CNT_W  = 16
);
   import rcu_multi_vc_pkg::*;

   localparam int VCW = vc_idx_width(NUM_VC);

   logic [NUM_VC-1:0]     req_valid;
   position_t [NUM_VC-1:0] req_dest;
   logic [NUM_VC-1:0]     req_ready;
   logic                  up_faulty;
   logic                  down_faulty;
   logic                  out_valid;
   logic                  out_ready;
   logic [VCW-1:0]        out_vc;
   port_t                 out_port;
   logic                  out_detour;
   logic                  out_err;
   logic [CNT_W-1:0]      detour_cnt;

   modport master (
      output req_valid, req_dest, up_faulty, down_faulty, out_ready,
      input  req_ready, out_valid, out_vc, out_port, out_detour, out_err, detour_cnt
   );

   modport slave (
      input  req_valid, req_dest, up_faulty, down_faulty, out_ready,
      output req_ready, out_valid, out_vc, out_port, out_detour, out_err, detour_cnt
   );

endinterface

// File: rtl/rcu_multi_vc_route_calc.sv
// Combinational Z-first route selection with lateral escape around a faulty vertical link.
module rcu_route_calc
   import rcu_multi_vc_pkg::*;
#(
   parameter position_t THIS_POS = '{x:'0, y:'0, z:'0},
   parameter bit        ADAPTIVE = 1'b1
) (
   input  position_t dest,
   input  logic      up_faulty,
   input  logic      down_faulty,
   input  logic      rand_bit,
   output port_t     port,
   output logic      detour,
   output logic      err
);

   logic [HOP_W-1:0] hop_x;
   logic [HOP_W-1:0] hop_y;
   logic [HOP_W-1:0] hop_z;
   direction_t       dir_x;
   direction_t       dir_y;
   direction_t       dir_z;

   assign hop_x = {1'b0, dest.x} - {1'b0, THIS_POS.x};
   assign hop_y = {1'b0, dest.y} - {1'b0, THIS_POS.y};
   assign hop_z = {1'b0, dest.z} - {1'b0, THIS_POS.z};
   assign dir_x = hop_dir(hop_x);
   assign dir_y = hop_dir(hop_y);
   assign dir_z = hop_dir(hop_z);

   // Vertical first; a blocked vertical link either escapes sideways (x move preferred, coin flip if none) or is flagged.
   always_comb begin
      port   = LOCAL;
      detour = 1'b0;
      err    = 1'b0;
      if (dir_z == POS && !up_faulty) begin
         port = UP;
      end else if (dir_z == NEG && !down_faulty) begin
         port = DOWN;
      end else if (dir_z != ZERO) begin
         if (ADAPTIVE) begin
            port   = (dir_x == POS || (dir_x == ZERO && rand_bit)) ? EAST : WEST;
            detour = (dir_x == ZERO);
         end else begin
            port = (dir_z == POS) ? UP : DOWN;
            err  = 1'b1;
         end
      end else if (dir_x == POS) begin
         port = EAST;
      end else if (dir_x == NEG) begin
         port = WEST;
      end else if (dir_y == POS) begin
         port = NORTH;
      end else if (dir_y == NEG) begin
         port = SOUTH;
      end
   end

endmodule

// File: rtl/rcu_multi_vc.sv
// Shared routing unit for one input port: round-robin VC arbitration, route computation, registered result.
module rcu_multi_vc
   import rcu_multi_vc_pkg::*;
#(
   parameter position_t   THIS_POS  = '{x:'0, y:'0, z:'0},
   parameter int          NUM_VC    = 4,
   parameter bit          ADAPTIVE  = 1'b1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          CNT_W     = 16
) (
   input logic          clk,
   input logic          rst_n,
   rcu_multi_vc_if.slave bus
);

   localparam int             VCW      = vc_idx_width(NUM_VC);
   localparam logic [VCW:0]   NUM_VC_W = (VCW+1)'(NUM_VC);
   localparam logic [VCW-1:0] LAST_VC  = VCW'(NUM_VC - 1);

   logic [VCW-1:0] rr_ptr;
   logic [VCW-1:0] gnt_idx;
   logic           gnt_found;
   logic           can_accept;
   logic           accept;
   logic [15:0]    lfsr;
   position_t      gnt_dest;
   port_t          calc_port;
   logic           calc_detour;
   logic           calc_err;

   assign can_accept = !bus.out_valid || bus.out_ready;
   assign accept     = rst_n && can_accept && gnt_found;
   assign gnt_dest   = bus.req_dest[gnt_idx];

   // Scan VCs starting at the round-robin pointer, wrapping, and take the first requester.
   always_comb begin
      logic [VCW:0] cand;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_VC; k++) begin
         cand = {1'b0, rr_ptr} + (VCW+1)'(k);
         if (cand >= NUM_VC_W) begin
            cand = cand - NUM_VC_W;
         end
         if (!gnt_found && bus.req_valid[cand[VCW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[VCW-1:0];
         end
      end
   end

   // One-hot acknowledge to the winning VC, only when the result register can take a new entry.
   always_comb begin
      bus.req_ready = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (accept && gnt_idx == VCW'(i)) begin
            bus.req_ready[i] = 1'b1;
         end
      end
   end

   rcu_route_calc #(
      .THIS_POS (THIS_POS),
      .ADAPTIVE (ADAPTIVE)
   ) u_route_calc (
      .dest        (gnt_dest),
      .up_faulty   (bus.up_faulty),
      .down_faulty (bus.down_faulty),
      .rand_bit    (lfsr[0]),
      .port        (calc_port),
      .detour      (calc_detour),
      .err         (calc_err)
   );

   // Pointer moves past the winner and the LFSR steps only when a request is actually accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr <= '0;
         lfsr   <= LFSR_SEED;
      end else if (accept) begin
         rr_ptr <= (gnt_idx == LAST_VC) ? '0 : gnt_idx + VCW'(1);
         lfsr   <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      end
   end

   // Result register: load on accept (overwriting a consumed entry), otherwise drain once consumed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid  <= 1'b0;
         bus.out_vc     <= '0;
         bus.out_port   <= LOCAL;
         bus.out_detour <= 1'b0;
         bus.out_err    <= 1'b0;
      end else if (accept) begin
         bus.out_valid  <= 1'b1;
         bus.out_vc     <= gnt_idx;
         bus.out_port   <= calc_port;
         bus.out_detour <= calc_detour;
         bus.out_err    <= calc_err;
      end else if (bus.out_ready) begin
         bus.out_valid  <= 1'b0;
      end
   end

   // Saturating tally of detours handed to the allocator.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.detour_cnt <= '0;
      end else if (accept && calc_detour && bus.detour_cnt != '1) begin
         bus.detour_cnt <= bus.detour_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_rcu_multi_vc.sv
// Bench for rcu_multi_vc: an adaptive unit (2-bit counter) and a non-adaptive unit share one stimulus stream.
module tb_rcu_multi_vc;
   import rcu_multi_vc_pkg::*;

   localparam int        NV   = 4;
   localparam position_t HOME = '{x:2'd1, y:2'd1, z:2'd1};

   typedef position_t [NV-1:0] dest_vec_t;

   typedef struct {
      position_t dest;
      bit        up;
      bit        down;
      port_t     portA;
      bit        detourA;
      port_t     portB;
      bit        errB;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checkCount = 0;
   int   errorCount = 0;

   int          modelPtr;
   logic [15:0] modelLfsr;
   bit          modelValid;
   int          modelVc;
   port_t       modelPortA;
   port_t       modelPortB;
   bit          modelDetA;
   bit          modelDetB;
   bit          modelErrA;
   bit          modelErrB;
   int          modelCntA;
   int          modelCntB;

   vec_t vecs[12];
   int   satSeq[5];

   always #5 clk = ~clk;

   rcu_multi_vc_if #(.NUM_VC(NV), .CNT_W(2))  bus_a ();
   rcu_multi_vc_if #(.NUM_VC(NV), .CNT_W(16)) bus_b ();

   assign bus_b.req_valid   = bus_a.req_valid;
   assign bus_b.req_dest    = bus_a.req_dest;
   assign bus_b.up_faulty   = bus_a.up_faulty;
   assign bus_b.down_faulty = bus_a.down_faulty;
   assign bus_b.out_ready   = bus_a.out_ready;

   rcu_multi_vc #(
      .THIS_POS (HOME), .NUM_VC (NV), .ADAPTIVE (1'b1), .LFSR_SEED (16'hACE1), .CNT_W (2)
   ) dut_a (
      .clk (clk), .rst_n (rst_n), .bus (bus_a)
   );

   rcu_multi_vc #(
      .THIS_POS (HOME), .NUM_VC (NV), .ADAPTIVE (1'b0), .LFSR_SEED (16'hACE1), .CNT_W (16)
   ) dut_b (
      .clk (clk), .rst_n (rst_n), .bus (bus_b)
   );

   function automatic position_t pos(input int x, input int y, input int z);
      position_t p;
      p.x = COORD_W'(x);
      p.y = COORD_W'(y);
      p.z = COORD_W'(z);
      return p;
   endfunction

   function automatic dest_vec_t allDest(input position_t p);
      dest_vec_t d;
      for (int i = 0; i < NV; i++) d[i] = p;
      return d;
   endfunction

   // Route from signed hop distances: vertical first, sideways escape when the vertical link is down.
   function automatic void refRoute(input position_t d, input bit up, input bit down, input bit r,
                                    input bit adaptive, output port_t p, output bit det, output bit err);
      int dx, dy, dz;
      bit blocked;
      dx = int'(d.x) - int'(HOME.x);
      dy = int'(d.y) - int'(HOME.y);
      dz = int'(d.z) - int'(HOME.z);
      p = LOCAL;
      det = 1'b0;
      err = 1'b0;
      if (dz != 0) begin
         blocked = (dz > 0) ? up : down;
         if (!blocked) p = (dz > 0) ? UP : DOWN;
         else if (!adaptive) begin
            p = (dz > 0) ? UP : DOWN;
            err = 1'b1;
         end else if (dx > 0) p = EAST;
         else if (dx < 0) p = WEST;
         else begin
            det = 1'b1;
            p = r ? EAST : WEST;
         end
      end else if (dx > 0) p = EAST;
      else if (dx < 0) p = WEST;
      else if (dy > 0) p = NORTH;
      else if (dy < 0) p = SOUTH;
   endfunction

   function automatic int refGrant(input logic [NV-1:0] v);
      logic [1:0] idx;
      for (int k = 0; k < NV; k++) begin
         idx = 2'((modelPtr + k) % NV);
         if (v[idx]) return int'(idx);
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkModel();
      checkOutput("out_valid_a", longint'(bus_a.out_valid), longint'(modelValid));
      checkOutput("out_valid_b", longint'(bus_b.out_valid), longint'(modelValid));
      if (modelValid) begin
         checkOutput("out_vc_a", longint'(bus_a.out_vc), longint'(modelVc));
         checkOutput("out_vc_b", longint'(bus_b.out_vc), longint'(modelVc));
         checkOutput("out_port_a", longint'(bus_a.out_port), longint'(modelPortA));
         checkOutput("out_port_b", longint'(bus_b.out_port), longint'(modelPortB));
         checkOutput("out_detour_a", longint'(bus_a.out_detour), longint'(modelDetA));
         checkOutput("out_detour_b", longint'(bus_b.out_detour), longint'(modelDetB));
         checkOutput("out_err_a", longint'(bus_a.out_err), longint'(modelErrA));
         checkOutput("out_err_b", longint'(bus_b.out_err), longint'(modelErrB));
      end
      checkOutput("detour_cnt_a", longint'(bus_a.detour_cnt), longint'(modelCntA));
      checkOutput("detour_cnt_b", longint'(bus_b.detour_cnt), longint'(modelCntB));
   endtask

   // Drive one cycle at the falling edge, check the acknowledge, clock it, update the model, check results.
   task automatic applyStimulus(input bit rstn, input logic [NV-1:0] v, input dest_vec_t d,
                                input bit up, input bit down, input bit rdy);
      logic [NV-1:0] expRdy;
      logic [1:0]    gi;
      int            g;
      bit            can;
      @(negedge clk);
      rst_n             = rstn;
      bus_a.req_valid   = v;
      bus_a.req_dest    = d;
      bus_a.up_faulty   = up;
      bus_a.down_faulty = down;
      bus_a.out_ready   = rdy;
      #1;
      can = !modelValid || rdy;
      g = refGrant(v);
      expRdy = '0;
      if (rstn && can && g >= 0) expRdy = NV'(1) << g;
      checkOutput("req_ready_a", longint'(bus_a.req_ready), longint'(expRdy));
      checkOutput("req_ready_b", longint'(bus_b.req_ready), longint'(expRdy));
      @(posedge clk);
      if (!rstn) begin
         modelValid = 1'b0;
         modelPtr   = 0;
         modelLfsr  = 16'hACE1;
         modelCntA  = 0;
         modelCntB  = 0;
      end else if (can && g >= 0) begin
         gi = 2'(g);
         refRoute(d[gi], up, down, modelLfsr[0], 1'b1, modelPortA, modelDetA, modelErrA);
         refRoute(d[gi], up, down, modelLfsr[0], 1'b0, modelPortB, modelDetB, modelErrB);
         modelValid = 1'b1;
         modelVc    = g;
         modelPtr   = (g + 1) % NV;
         modelLfsr  = {modelLfsr[14:0], modelLfsr[15] ^ modelLfsr[13] ^ modelLfsr[12] ^ modelLfsr[10]};
         if (modelDetA && modelCntA < 3) modelCntA++;
         if (modelDetB && modelCntB < 65535) modelCntB++;
      end else if (rdy) begin
         modelValid = 1'b0;
      end
      #1;
      checkModel();
   endtask

   initial begin
      rst_n             = 1'b0;
      bus_a.req_valid   = '0;
      bus_a.req_dest    = '0;
      bus_a.up_faulty   = 1'b0;
      bus_a.down_faulty = 1'b0;
      bus_a.out_ready   = 1'b0;
      modelValid = 1'b0;
      modelPtr   = 0;
      modelLfsr  = 16'hACE1;
      modelCntA  = 0;
      modelCntB  = 0;

      vecs[0]  = '{pos(1,1,1), 1'b0, 1'b0, LOCAL, 1'b0, LOCAL, 1'b0};
      vecs[1]  = '{pos(1,2,3), 1'b0, 1'b0, UP,    1'b0, UP,    1'b0};
      vecs[2]  = '{pos(3,1,0), 1'b0, 1'b1, EAST,  1'b0, DOWN,  1'b1};
      vecs[3]  = '{pos(2,1,1), 1'b0, 1'b0, EAST,  1'b0, EAST,  1'b0};
      vecs[4]  = '{pos(0,1,1), 1'b1, 1'b1, WEST,  1'b0, WEST,  1'b0};
      vecs[5]  = '{pos(1,3,1), 1'b0, 1'b0, NORTH, 1'b0, NORTH, 1'b0};
      vecs[6]  = '{pos(1,0,1), 1'b0, 1'b0, SOUTH, 1'b0, SOUTH, 1'b0};
      vecs[7]  = '{pos(1,1,0), 1'b1, 1'b0, DOWN,  1'b0, DOWN,  1'b0};
      vecs[8]  = '{pos(0,1,3), 1'b1, 1'b0, WEST,  1'b0, UP,    1'b1};
      vecs[9]  = '{pos(2,3,1), 1'b1, 1'b1, EAST,  1'b0, EAST,  1'b0};
      vecs[10] = '{pos(3,0,2), 1'b1, 1'b0, EAST,  1'b0, UP,    1'b1};
      vecs[11] = '{pos(1,0,0), 1'b0, 1'b0, DOWN,  1'b0, DOWN,  1'b0};
      satSeq = '{1, 2, 3, 3, 3};

      // Reset held two cycles with every VC requesting.
      repeat (2) applyStimulus(1'b0, 4'hF, allDest(HOME), 1'b0, 1'b0, 1'b1);
      checkOutput("reset req_ready", longint'(bus_a.req_ready), 0);
      checkOutput("reset out_valid", longint'(bus_a.out_valid), 0);
      checkOutput("reset out_port", longint'(bus_a.out_port), longint'(LOCAL));
      checkOutput("reset detour_cnt", longint'(bus_a.detour_cnt), 0);

      // Round robin over four always-valid VCs, starting at VC0.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 4'hF, allDest(HOME), 1'b0, 1'b0, 1'b1);
         checkOutput("rr out_vc", longint'(bus_a.out_vc), longint'(i % NV));
         checkOutput("rr out_valid", longint'(bus_a.out_valid), 1);
         checkOutput("rr out_port", longint'(bus_a.out_port), longint'(LOCAL));
      end

      // Directed route table.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 4'hF, allDest(vecs[i].dest), vecs[i].up, vecs[i].down, 1'b1);
         checkOutput($sformatf("vec%0d port_a", i), longint'(bus_a.out_port), longint'(vecs[i].portA));
         checkOutput($sformatf("vec%0d detour_a", i), longint'(bus_a.out_detour), longint'(vecs[i].detourA));
         checkOutput($sformatf("vec%0d port_b", i), longint'(bus_b.out_port), longint'(vecs[i].portB));
         checkOutput($sformatf("vec%0d err_b", i), longint'(bus_b.out_err), longint'(vecs[i].errB));
      end

      // Vertical detour straight after reset: seed bit0 is 1, so the escape goes EAST.
      applyStimulus(1'b0, 4'h0, allDest(HOME), 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'h1, allDest(pos(1,2,3)), 1'b1, 1'b0, 1'b1);
      checkOutput("detour port", longint'(bus_a.out_port), longint'(EAST));
      checkOutput("detour flag", longint'(bus_a.out_detour), 1);
      checkOutput("detour cnt", longint'(bus_a.detour_cnt), 1);
      applyStimulus(1'b1, 4'h1, allDest(pos(1,2,3)), 1'b0, 1'b0, 1'b1);
      checkOutput("healthy up port", longint'(bus_a.out_port), longint'(UP));
      checkOutput("healthy up detour", longint'(bus_a.out_detour), 0);

      // Productive lateral escape versus the non-adaptive error flag.
      applyStimulus(1'b1, 4'h1, allDest(pos(3,1,0)), 1'b0, 1'b1, 1'b1);
      checkOutput("lateral port_a", longint'(bus_a.out_port), longint'(EAST));
      checkOutput("lateral detour_a", longint'(bus_a.out_detour), 0);
      checkOutput("lateral port_b", longint'(bus_b.out_port), longint'(DOWN));
      checkOutput("lateral err_b", longint'(bus_b.out_err), 1);

      // Backpressure: three stalled cycles with VC2 waiting, then release.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'h4, allDest(pos(2,1,1)), 1'b0, 1'b0, 1'b0);
         checkOutput("stall req_ready", longint'(bus_a.req_ready), 0);
         checkOutput("stall out_valid", longint'(bus_a.out_valid), 1);
         checkOutput("stall out_port", longint'(bus_a.out_port), longint'(EAST));
         checkOutput("stall out_vc", longint'(bus_a.out_vc), 0);
      end
      applyStimulus(1'b1, 4'h4, allDest(pos(2,1,1)), 1'b0, 1'b0, 1'b1);
      checkOutput("release out_vc", longint'(bus_a.out_vc), 2);
      checkOutput("release out_port", longint'(bus_a.out_port), longint'(EAST));

      // Counter saturation on the 2-bit unit, then reset during a stall.
      applyStimulus(1'b0, 4'h0, allDest(HOME), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 4'h1, allDest(pos(1,1,3)), 1'b1, 1'b0, 1'b1);
         checkOutput("sat detour_cnt", longint'(bus_a.detour_cnt), longint'(satSeq[i]));
      end
      applyStimulus(1'b1, 4'h0, allDest(HOME), 1'b0, 1'b0, 1'b0);
      checkOutput("held out_valid", longint'(bus_a.out_valid), 1);
      applyStimulus(1'b0, 4'h0, allDest(HOME), 1'b0, 1'b0, 1'b0);
      checkOutput("reset in stall out_valid", longint'(bus_a.out_valid), 0);

      // Randomised traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         dest_vec_t d;
         for (int i = 0; i < NV; i++) d[i] = pos($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         applyStimulus($urandom_range(0, 49) != 0, NV'($urandom_range(0, 15)), d,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
